// File: rtl/rv32_pkg.sv
// rv32_pkg: shared constants and types for the regfile writeback path
package rv32_pkg;
  localparam int XLEN = 32;
  localparam int REG_AW = 5;
  localparam int NREGS = 1 << REG_AW;
  typedef logic [REG_AW-1:0] reg_addr_t;
  typedef enum logic {WB_ALU = 1'b0, WB_MEM = 1'b1} wb_src_e;
endpackage

// File: rtl/rf_scoreboard.sv
// rf_scoreboard: per-register pending-write bits with set/clear/flush and two query ports
module rf_scoreboard import rv32_pkg::*; #(
  parameter int AW = REG_AW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          set,
  input  logic [AW-1:0] set_rd,
  input  logic          clr,
  input  logic [AW-1:0] clr_rd,
  input  logic          flush,
  input  logic [AW-1:0] q_a1,
  input  logic [AW-1:0] q_a2,
  output logic          busy1,
  output logic          busy2
);
  logic [(1<<AW)-1:0] busy, busy_nxt;
  // clear first so a same-cycle reservation (newer producer) wins; x0 never busy
  always_comb begin
    busy_nxt = busy;
    if (clr) busy_nxt[clr_rd] = 1'b0;
    if (set) busy_nxt[set_rd] = 1'b1;
    if (flush) busy_nxt = '0;
    busy_nxt[0] = 1'b0;
  end
  // busy vector register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) busy <= '0;
    else busy <= busy_nxt;
  assign busy1 = busy[q_a1];
  assign busy2 = busy[q_a2];
endmodule

// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: round-robin share of the regfile write port between ALU and load writeback
module rf_wb_arbiter import rv32_pkg::wb_src_e, rv32_pkg::WB_ALU, rv32_pkg::WB_MEM; #(
  parameter int XLEN    = 32,
  parameter int AW      = 5,
  parameter bit RR_INIT = 1'b0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            alu_valid,
  output logic            alu_ready,
  input  logic [AW-1:0]   alu_rd,
  input  logic [XLEN-1:0] alu_data,
  input  logic            mem_valid,
  output logic            mem_ready,
  input  logic [AW-1:0]   mem_rd,
  input  logic [XLEN-1:0] mem_data,
  output logic            rf_we3,
  output logic [AW-1:0]   rf_a3,
  output logic [XLEN-1:0] rf_wd3,
  input  logic            rsv_valid,
  input  logic [AW-1:0]   rsv_rd,
  input  logic            flush,
  input  logic [AW-1:0]   q_a1,
  input  logic [AW-1:0]   q_a2,
  output logic            busy1,
  output logic            busy2
);
  wb_src_e         rr_ptr;
  logic            acc;
  logic [AW-1:0]   rd;
  logic [XLEN-1:0] data;
  assign alu_ready = alu_valid & (~mem_valid | (rr_ptr == WB_ALU));
  assign mem_ready = mem_valid & (~alu_valid | (rr_ptr == WB_MEM));
  assign acc  = alu_ready | mem_ready;
  assign rd   = alu_ready ? alu_rd : mem_rd;
  assign data = alu_ready ? alu_data : mem_data;
  // after a grant, favour the source that was not granted
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) rr_ptr <= wb_src_e'(RR_INIT);
    else if (alu_ready) rr_ptr <= WB_MEM;
    else if (mem_ready) rr_ptr <= WB_ALU;
  // registered write port; x0 writes complete the handshake but never enable
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rf_we3 <= 1'b0;
      rf_a3  <= '0;
      rf_wd3 <= '0;
    end else begin
      rf_we3 <= acc && (rd != '0);
      if (acc) begin
        rf_a3  <= rd;
        rf_wd3 <= data;
      end
    end
  rf_scoreboard #(.AW(AW)) u_sb (
    .clk    (clk),
    .rst_n  (rst_n),
    .set    (rsv_valid),
    .set_rd (rsv_rd),
    .clr    (rf_we3),
    .clr_rd (rf_a3),
    .flush  (flush),
    .q_a1   (q_a1),
    .q_a2   (q_a2),
    .busy1  (busy1),
    .busy2  (busy2)
  );
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// tb_rf_wb_arbiter: scoreboard bench with a behavioural model of grants, writes and busy bits
module tb_rf_wb_arbiter;
  logic clk = 1'b0, rst_n = 1'b1;
  logic alu_valid = 0, mem_valid = 0, rsv_valid = 0, flush = 0;
  logic alu_ready, mem_ready, rf_we3, busy1, busy2;
  logic [4:0] alu_rd = 0, mem_rd = 0, rsv_rd = 0, q_a1 = 0, q_a2 = 0, rf_a3;
  logic [31:0] alu_data = 0, mem_data = 0, rf_wd3;
  always #5 clk = ~clk;
  rf_wb_arbiter #(.XLEN(32), .AW(5), .RR_INIT(1'b0)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_data(mem_data),
    .rf_we3(rf_we3), .rf_a3(rf_a3), .rf_wd3(rf_wd3),
    .rsv_valid(rsv_valid), .rsv_rd(rsv_rd), .flush(flush),
    .q_a1(q_a1), .q_a2(q_a2), .busy1(busy1), .busy2(busy2)
  );
  typedef struct {logic [4:0] rd; logic [31:0] d; int unsigned due;} wr_t;
  wr_t exp_q[$];
  int unsigned edge_cnt = 0;
  bit bm[32];
  bit favour_mem = 0, fl_v = 0, lg_a = 0, lg_m = 0;
  logic [4:0] fl_rd = 0;
  int n_cmp = 0, n_bad = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;
  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  // monitor: every regfile write must match the oldest expected write, one edge after its grant
  always @(negedge clk) if (rst_n) begin
    wr_t w;
    if (rf_we3) begin
      if (exp_q.size() == 0) chk("unexpected_write", rf_we3, 0);
      else begin
        w = exp_q.pop_front();
        chk("wr_a3", rf_a3, w.rd);
        chk("wr_wd3", rf_wd3, w.d);
        chk("wr_latency", edge_cnt, w.due);
      end
    end else if (exp_q.size() != 0 && exp_q[0].due <= edge_cnt) begin
      chk("missing_write", rf_we3, 1);
      void'(exp_q.pop_front());
    end
  end
  task automatic drive(bit av, logic [4:0] ar, logic [31:0] ad, bit mv, logic [4:0] mr,
                       logic [31:0] md, bit rv, logic [4:0] rr, bit fl, logic [4:0] q1, logic [4:0] q2);
    alu_valid = av; alu_rd = ar; alu_data = ad;
    mem_valid = mv; mem_rd = mr; mem_data = md;
    rsv_valid = rv; rsv_rd = rr; flush = fl; q_a1 = q1; q_a2 = q2;
  endtask
  task automatic step();
    bit ga, gm;
    logic [4:0] rd;
    @(negedge clk);
    ga = alu_valid && (!mem_valid || !favour_mem);
    gm = mem_valid && (!alu_valid || favour_mem);
    chk("alu_ready", alu_ready, ga);
    chk("mem_ready", mem_ready, gm);
    chk("busy1", busy1, q_a1 != 0 && bm[q_a1]);
    chk("busy2", busy2, q_a2 != 0 && bm[q_a2]);
    @(posedge clk);
    if (flush) bm = '{default: 0};
    else begin
      if (fl_v) bm[fl_rd] = 0;
      if (rsv_valid && rsv_rd != 0) bm[rsv_rd] = 1;
    end
    rd = ga ? alu_rd : mem_rd;
    fl_v = (ga || gm) && rd != 0;
    fl_rd = rd;
    if (fl_v) exp_q.push_back('{rd, ga ? alu_data : mem_data, edge_cnt + 1});
    if (ga) favour_mem = 1; else if (gm) favour_mem = 0;
    lg_a = ga; lg_m = gm;
    #1;
  endtask
  initial begin
    #1 rst_n = 0;
    #2;
    chk("rst_we3", rf_we3, 0);
    chk("rst_a3", rf_a3, 0);
    chk("rst_wd3", rf_wd3, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    drive(1, 1, 42, 0, 0, 0, 0, 0, 0, 1, 0); step();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0); step(); step();
    drive(0, 0, 0, 1, 0, 99, 0, 0, 0, 0, 0); step();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); step(); step();
    drive(1, 3, 7, 1, 4, 8, 0, 0, 0, 3, 4);
    repeat (5) step();
    drive(0, 0, 0, 0, 0, 0, 1, 5, 0, 5, 0); step();
    drive(1, 5, 32'h55, 0, 0, 0, 0, 0, 0, 5, 0); step();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 5, 0); step(); step();
    drive(1, 6, 32'h66, 0, 0, 0, 1, 6, 0, 6, 5); step();
    drive(0, 0, 0, 0, 0, 0, 1, 6, 0, 6, 0); step();
    drive(0, 0, 0, 0, 0, 0, 1, 7, 1, 6, 7); step();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 6, 7); step();
    drive(0, 0, 0, 0, 0, 0, 1, 9, 0, 9, 0); step();
    drive(1, 9, 123, 0, 0, 0, 0, 0, 0, 9, 0); step();
    chk("pre_reset_we3", rf_we3, 1);
    #2 rst_n = 0;
    #1;
    chk("async_we3", rf_we3, 0);
    chk("async_a3", rf_a3, 0);
    chk("async_wd3", rf_wd3, 0);
    chk("async_busy1", busy1, 0);
    bm = '{default: 0}; favour_mem = 0; fl_v = 0; lg_a = 0; lg_m = 0; exp_q.delete();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 9, 0);
    @(posedge clk); #1 rst_n = 1;
    drive(1, 10, 32'hA, 1, 11, 32'hB, 0, 0, 0, 10, 11); step(); step();
    for (int i = 0; i < 400; i++) begin
      if (!(alu_valid && !lg_a)) begin
        alu_valid = $urandom_range(0, 3) != 0; alu_rd = 5'($urandom_range(0, 7)); alu_data = $urandom;
      end
      if (!(mem_valid && !lg_m)) begin
        mem_valid = $urandom_range(0, 3) != 0; mem_rd = 5'($urandom_range(0, 7)); mem_data = $urandom;
      end
      rsv_valid = $urandom_range(0, 1) != 0; rsv_rd = 5'($urandom_range(0, 7));
      flush = $urandom_range(0, 15) == 0;
      q_a1 = 5'($urandom_range(0, 7)); q_a2 = 5'($urandom_range(0, 7));
      step();
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) step();
    chk("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
